// File: rtl/lane_dispatch_seq.sv
// Round-robin dispatcher from a valid/ready operand stream onto up to 32 PE lanes.
// Emits a registered lane code, data word and strobe, plus row and job completion pulses.
module lane_dispatch_seq #(
    parameter int DATA_W = 16,
    parameter int CODE_W = 5,
    parameter int ROW_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        cfg_lanes,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic [CODE_W-1:0] wr_code,
    output logic [DATA_W-1:0] wr_data,
    output logic              row_done,
    output logic              job_done,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for start; cfg sampled here only
    // RUN   | accepting words, one per cycle, dispatching round-robin
    // DONE  | single-cycle wrap-up; job_done is raised on the exit edge
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_d;
    logic [5:0]          lanes_eff, lanes_eff_d;
    logic [ROW_W-1:0]    rows_eff, rows_eff_d;
    logic [5:0]          lane_cnt, lane_cnt_d;
    logic [ROW_W-1:0]    row_cnt, row_cnt_d;
    logic                wr_en_d, row_done_d, job_done_d;
    logic [CODE_W-1:0]   wr_code_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                xfer, last_lane;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign xfer      = in_valid && in_ready;
    assign last_lane = (lane_cnt == lanes_eff - 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lanes_eff <= '0;
            rows_eff  <= '0;
            lane_cnt  <= '0;
            row_cnt   <= '0;
            wr_en     <= 1'b0;
            wr_code   <= '0;
            wr_data   <= '0;
            row_done  <= 1'b0;
            job_done  <= 1'b0;
        end else begin
            state     <= state_d;
            lanes_eff <= lanes_eff_d;
            rows_eff  <= rows_eff_d;
            lane_cnt  <= lane_cnt_d;
            row_cnt   <= row_cnt_d;
            wr_en     <= wr_en_d;
            wr_code   <= wr_code_d;
            wr_data   <= wr_data_d;
            row_done  <= row_done_d;
            job_done  <= job_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        lanes_eff_d = lanes_eff;
        rows_eff_d  = rows_eff;
        lane_cnt_d  = lane_cnt;
        row_cnt_d   = row_cnt;
        wr_en_d     = 1'b0;
        wr_code_d   = wr_code;
        wr_data_d   = wr_data;
        row_done_d  = 1'b0;
        job_done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    lanes_eff_d = (cfg_lanes == 6'd0 || cfg_lanes > 6'd32) ? 6'd32 : cfg_lanes;
                    rows_eff_d  = cfg_rows;
                    lane_cnt_d  = '0;
                    row_cnt_d   = '0;
                    state_d     = (cfg_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_code_d = lane_cnt[CODE_W-1:0];
                    wr_data_d = in_data;
                    if (last_lane) begin
                        lane_cnt_d = '0;
                        row_cnt_d  = row_cnt + ROW_W'(1);
                        row_done_d = 1'b1;
                        // Last word of the job: stop accepting from the next cycle on.
                        if (row_cnt == rows_eff - ROW_W'(1))
                            state_d = DONE;
                    end else begin
                        lane_cnt_d = lane_cnt + 6'd1;
                    end
                end
            end
            DONE: begin
                job_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lane_dispatch_seq.sv
// Directed bench for lane_dispatch_seq; inputs change 1 time unit after each rising edge,
// outputs are checked at that same point against hand-computed values.
module tb_lane_dispatch_seq;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [5:0]  cfg_lanes;
    logic [15:0] cfg_rows;
    logic [15:0] in_data;
    logic        in_ready, wr_en, row_done, job_done, busy;
    logic [4:0]  wr_code;
    logic [15:0] wr_data;

    int checks   = 0;
    int failures = 0;

    lane_dispatch_seq #(.DATA_W(16), .CODE_W(5), .ROW_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_lanes(cfg_lanes), .cfg_rows(cfg_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_code(wr_code), .wr_data(wr_data),
        .row_done(row_done), .job_done(job_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_row_done"}, row_done, 0);
    endtask

    int k;
    logic [4:0]  last_code;
    logic [15:0] last_data;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_lanes = 6'd0; cfg_rows = 16'd0;
        tick(); tick();
        chk_idle_outputs("reset");
        chk("reset_job_done", job_done, 0);
        chk("reset_wr_code", wr_code, 0);
        chk("reset_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();

        // 4 lanes x 2 rows, continuous stream
        start = 1'b1; cfg_lanes = 6'd4; cfg_rows = 16'd2; in_valid = 1'b1; in_data = 16'h10;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h10 + 16'(i);
            tick();
            chk("t1_wr_en", wr_en, 1);
            chk("t1_wr_code", wr_code, i % 4);
            chk("t1_wr_data", wr_data, 16'h10 + i);
            chk("t1_row_done", row_done, (i % 4) == 3);
            chk("t1_job_done_early", job_done, 0);
        end
        chk("t1_in_ready_done", in_ready, 0);
        tick();
        chk("t1_job_done", job_done, 1);
        chk_idle_outputs("t1_after");
        tick();
        chk("t1_job_done_pulse", job_done, 0);
        chk("t1_in_ready_idle", in_ready, 0);
        in_valid = 1'b0;

        // cfg_lanes 0 and 40 both mean 32 lanes
        for (int c = 0; c < 2; c++) begin
            start = 1'b1; cfg_lanes = (c == 0) ? 6'd0 : 6'd40; cfg_rows = 16'd1;
            tick();
            start = 1'b0; in_valid = 1'b1;
            for (int i = 0; i < 32; i++) begin
                in_data = 16'h200 + 16'(i);
                tick();
                chk("t2_wr_en", wr_en, 1);
                chk("t2_wr_code", wr_code, i);
                chk("t2_wr_data", wr_data, 16'h200 + i);
                chk("t2_row_done", row_done, i == 31);
            end
            tick();
            chk("t2_job_done", job_done, 1);
            chk("t2_wr_en_off", wr_en, 0);
            in_valid = 1'b0;
            tick();
        end

        // empty job
        start = 1'b1; cfg_lanes = 6'd4; cfg_rows = 16'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        chk_idle_outputs("t3_c1");
        chk("t3_job_done_c1", job_done, 0);
        tick();
        chk_idle_outputs("t3_c2");
        chk("t3_job_done_c2", job_done, 1);
        tick();
        chk("t3_job_done_c3", job_done, 0);
        chk("t3_wr_en_c3", wr_en, 0);
        in_valid = 1'b0;

        // 3 lanes x 2 rows, in_valid 1,0,0 pattern
        start = 1'b1; cfg_lanes = 6'd3; cfg_rows = 16'd2;
        tick();
        start = 1'b0;
        k = 0; last_code = '0; last_data = '0;
        for (int s = 0; s < 16; s++) begin
            in_valid = (s % 3) == 0;
            in_data  = 16'h300 + 16'(s);
            tick();
            if ((s % 3) == 0) begin
                last_code = 5'(k % 3);
                last_data = 16'h300 + 16'(s);
                chk("t4_wr_en", wr_en, 1);
                chk("t4_row_done", row_done, (k % 3) == 2);
                k++;
            end else begin
                chk("t4_wr_en_gap", wr_en, 0);
                chk("t4_row_done_gap", row_done, 0);
            end
            chk("t4_wr_code", wr_code, last_code);
            chk("t4_wr_data", wr_data, last_data);
        end
        in_valid = 1'b0;
        tick();
        chk("t4_job_done", job_done, 1);
        tick();

        // reset mid-job, then restart
        start = 1'b1; cfg_lanes = 6'd32; cfg_rows = 16'd4;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h500 + 16'(i);
            tick();
            chk("t5_wr_code", wr_code, i);
        end
        rst = 1'b1;
        tick();
        chk_idle_outputs("t5_rst");
        chk("t5_rst_job_done", job_done, 0);
        chk("t5_rst_wr_code", wr_code, 0);
        chk("t5_rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();
        chk("t5_idle_wr_en", wr_en, 0);
        chk("t5_idle_in_ready", in_ready, 0);
        start = 1'b1; cfg_lanes = 6'd4; cfg_rows = 16'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h600 + 16'(i);
            tick();
            chk("t5_restart_code", wr_code, i);
            chk("t5_restart_data", wr_data, 16'h600 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("t5_job_done", job_done, 1);
        tick();

        // start while busy and cfg change mid-job are ignored
        start = 1'b1; cfg_lanes = 6'd4; cfg_rows = 16'd2;
        tick();
        start = 1'b0; cfg_lanes = 6'd8; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start   = (i == 2) || (i == 5);
            in_data = 16'h700 + 16'(i);
            tick();
            chk("t6_wr_en", wr_en, 1);
            chk("t6_wr_code", wr_code, i % 4);
            chk("t6_row_done", row_done, (i % 4) == 3);
        end
        start = 1'b0;
        chk("t6_in_ready_done", in_ready, 0);
        tick();
        chk("t6_job_done", job_done, 1);
        chk("t6_wr_en_off", wr_en, 0);
        in_valid = 1'b0;
        tick();
        chk("t6_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
